aes_key_schedule_ctrl: RTL

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key via a start/ready handshake and drives the existing GENERATE_KEY single-round expansion module once per cycle for rounds 0..9. All 11 round keys (rk0 = cipher key through rk10) are stored in an internal register file. The cipher round datapath reads round keys by index through a combinational read port.

---
 rtl/aes_key_schedule_ctrl_pkg.sv | 11 +
 rtl/aes_key_schedule_ctrl_if.sv | 24 ++
 rtl/aes_key_schedule_ctrl_generate_key.sv | 65 ++++++
 rtl/aes_key_schedule_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared AES-128 key-schedule constants and controller state encoding.
package aes_pkg;
  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_RK_CNT = 11;

  typedef enum logic {
    KS_IDLE,
    KS_EXPAND
  } ks_state_t;
endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Start/flush handshake and round-key read port of the key-schedule controller.
interface aes_key_schedule_ctrl_if;
  import aes_pkg::*;

  logic                 start;
  logic [AES_KEY_W-1:0] key_in;
  logic                 flush;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic                 keys_valid;
  logic [3:0]           rd_idx;
  logic [AES_KEY_W-1:0] rd_key;

  modport master (
    output start, key_in, flush, rd_idx,
    input  ready, busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, flush, rd_idx,
    output ready, busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/aes_key_schedule_ctrl_generate_key.sv
// GENERATE_KEY: combinational single-round AES-128 key expansion (rk[n] -> rk[n+1]).
module GENERATE_KEY (
  input  logic [3:0]   round,
  input  logic [127:0] inp_key,
  output logic [127:0] out_key
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] inv;
    t = x;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), x);
    inv = gf_mul(t, t);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3, rot_w, temp_w, w4, w5, w6, w7;

  always_comb begin
    w0     = inp_key[127:96];
    w1     = inp_key[95:64];
    w2     = inp_key[63:32];
    w3     = inp_key[31:0];
    rot_w  = {w3[23:0], w3[31:24]};
    temp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
             ^ {rcon(round), 24'h0};
    w4     = w0 ^ temp_w;
    w5     = w4 ^ w1;
    w6     = w5 ^ w2;
    w7     = w6 ^ w3;
    out_key = {w4, w5, w6, w7};
  end
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller: expands one round per cycle into an 11-entry
// round-key register file with a combinational indexed read port.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_key_schedule_ctrl_if.slave  ks
);
  ks_state_t        state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic [KEY_W-1:0] rk_q [AES_RK_CNT];
  logic [KEY_W-1:0] rk_d [AES_RK_CNT];
  logic             done_q, done_d;
  logic             keys_valid_q, keys_valid_d;
  logic [KEY_W-1:0] gen_out;

  GENERATE_KEY u_generate_key (
    .round   (rnd_q),
    .inp_key (cur_key_q),
    .out_key (gen_out)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    cur_key_d    = cur_key_q;
    rk_d         = rk_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;

    // flush wins over start; the stored round keys are deliberately kept.
    if (ks.flush) begin
      state_d      = KS_IDLE;
      rnd_d        = '0;
      keys_valid_d = 1'b0;
    end else begin
      case (state_q)
        KS_IDLE: begin
          if (ks.start) begin
            rk_d[0]      = ks.key_in;
            cur_key_d    = ks.key_in;
            rnd_d        = '0;
            keys_valid_d = 1'b0;
            state_d      = KS_EXPAND;
          end
        end
        KS_EXPAND: begin
          for (int i = 1; i < AES_RK_CNT; i++) begin
            if (rnd_q == 4'(i - 1)) rk_d[i] = gen_out;
          end
          cur_key_d = gen_out;
          if (rnd_q == 4'(NR - 1)) begin
            rnd_d        = '0;
            state_d      = KS_IDLE;
            done_d       = 1'b1;
            keys_valid_d = 1'b1;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        default: state_d = KS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= KS_IDLE;
      rnd_q        <= '0;
      cur_key_q    <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < AES_RK_CNT; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cur_key_q    <= cur_key_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_q         <= rk_d;
    end
  end

  always_comb begin
    ks.rd_key = '0;
    for (int i = 0; i < AES_RK_CNT; i++) begin
      if (ks.rd_idx == 4'(i)) ks.rd_key = rk_q[i];
    end
  end

  assign ks.ready      = (state_q == KS_IDLE);
  assign ks.busy       = (state_q == KS_EXPAND);
  assign ks.done       = done_q;
  assign ks.keys_valid = keys_valid_q;
endmodule
